// File: rtl/pipe_pkg.sv
// Shared definitions for the elastic pipeline registers between pipeline stages.
// Occupancy-state encodings and default payload widths for each stage boundary.
package pipe_pkg;

  localparam logic [1:0] PS_EMPTY = 2'd0;
  localparam logic [1:0] PS_BUSY  = 2'd1;
  localparam logic [1:0] PS_FULL  = 2'd2;

  localparam int IFID_W  = 64;
  localparam int IDEX_W  = 128;
  localparam int EXMEM_W = 96;
  localparam int MEMWB_W = 72;

endpackage

// File: rtl/dff_en_nbit.sv
// WIDTH-bit register with synchronous active-high reset and load enable.
// Reset wins over enable; with enable low the register holds its value.
module dff_en_nbit #(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q <= RST_VAL;
    end else if (i_en) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/pipe_skid_reg.sv
// Two-entry valid/ready skid buffer used as a pipeline-stage boundary register.
// in_ready is decoded from the state flops only, so it never depends on out_ready.
//
//   state    | meaning
//   ---------+-----------------------------------------------------
//   PS_EMPTY | nothing held, out_valid=0, in_ready=1
//   PS_BUSY  | main slot valid, skid empty, in_ready=1
//   PS_FULL  | main and skid valid (main older), in_ready=0
module pipe_skid_reg
  import pipe_pkg::*;
#(
  parameter int               WIDTH   = 16,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy
);

  logic [1:0]       w_state;
  logic [1:0]       w_state_d;
  logic             w_accept;
  logic             w_consume;
  logic             w_main_en;
  logic             w_skid_en;
  logic [WIDTH-1:0] w_main_d;
  logic [WIDTH-1:0] w_main_q;
  logic [WIDTH-1:0] w_skid_q;

  assign in_ready  = (w_state != PS_FULL);
  assign out_valid = (w_state != PS_EMPTY);
  assign occupancy = w_state;
  assign out_data  = w_main_q;

  assign w_accept  = in_valid & in_ready;
  assign w_consume = out_valid & out_ready;

  always_comb begin
    w_state_d = w_state;
    w_main_en = 1'b0;
    w_skid_en = 1'b0;
    w_main_d  = in_data;
    case (w_state)
      PS_EMPTY: begin
        if (w_accept) begin
          w_main_en = 1'b1;
          w_state_d = PS_BUSY;
        end
      end
      PS_BUSY: begin
        if (w_accept && w_consume) begin
          w_main_en = 1'b1;
        end else if (w_accept) begin
          w_skid_en = 1'b1;
          w_state_d = PS_FULL;
        end else if (w_consume) begin
          w_state_d = PS_EMPTY;
        end
      end
      PS_FULL: begin
        if (w_consume) begin
          w_main_d  = w_skid_q;
          w_main_en = 1'b1;
          w_state_d = PS_BUSY;
        end
      end
      default: w_state_d = PS_EMPTY;
    endcase
    // Flush discards everything, including a same-cycle accept; data flops keep their contents.
    if (flush) begin
      w_state_d = PS_EMPTY;
      w_main_en = 1'b0;
      w_skid_en = 1'b0;
    end
  end

  dff_en_nbit #(.WIDTH(2), .RST_VAL(PS_EMPTY)) u_state (
    .clk  (clk),
    .rst  (rst),
    .i_en (1'b1),
    .i_d  (w_state_d),
    .o_q  (w_state)
  );

  dff_en_nbit #(.WIDTH(WIDTH), .RST_VAL(RST_VAL)) u_main (
    .clk  (clk),
    .rst  (rst),
    .i_en (w_main_en),
    .i_d  (w_main_d),
    .o_q  (w_main_q)
  );

  dff_en_nbit #(.WIDTH(WIDTH), .RST_VAL(RST_VAL)) u_skid (
    .clk  (clk),
    .rst  (rst),
    .i_en (w_skid_en),
    .i_d  (in_data),
    .o_q  (w_skid_q)
  );

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Bench for pipe_skid_reg: directed scenarios plus a long random run against a
// two-entry FIFO reference model (queue of held entries, capacity 2).
module tb_pipe_skid_reg;

  localparam int          W  = 16;
  localparam logic [15:0] RV = 16'h5A5A;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic [1:0]    occupancy;

  int            n_checks = 0;
  int            n_errors = 0;

  logic [W-1:0]  mq[$];
  logic [W-1:0]  got[$];
  logic          prev_hold = 1'b0;
  logic [W-1:0]  prev_data = '0;

  always #5 clk = ~clk;

  pipe_skid_reg #(.WIDTH(W), .RST_VAL(RV)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive, compare outputs with the model, advance the model at the edge.
  task automatic step(input logic v, input logic [W-1:0] d, input logic rdy,
                      input logic fl, input logic rs, output logic acc);
    logic cons;
    in_valid  = v;
    in_data   = d;
    out_ready = rdy;
    flush     = fl;
    rst       = rs;
    #1;
    chk("occupancy", {30'd0, occupancy}, mq.size());
    chk("out_valid", {31'd0, out_valid}, {31'd0, mq.size() > 0});
    chk("in_ready", {31'd0, in_ready}, {31'd0, mq.size() < 2});
    chk("occ_not_3", {31'd0, occupancy == 2'd3}, 32'd0);
    if (mq.size() > 0) chk("out_data", {16'd0, out_data}, {16'd0, mq[0]});
    if (prev_hold) chk("stall_stable", {16'd0, out_data}, {16'd0, prev_data});
    acc  = v && (mq.size() < 2) && !fl && !rs;
    cons = (mq.size() > 0) && rdy;
    if (cons && !rs) got.push_back(mq[0]);
    prev_hold = (mq.size() > 0) && !rdy && !fl && !rs;
    prev_data = out_data;
    @(posedge clk);
    if (rs || fl) begin
      mq.delete();
    end else begin
      if (cons) void'(mq.pop_front());
      if (acc) mq.push_back(d);
    end
    @(negedge clk);
  endtask

  task automatic chk_empty(input string tag);
    chk({tag, "_valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_ready"}, {31'd0, in_ready}, 32'd1);
    chk({tag, "_occ"}, {30'd0, occupancy}, 32'd0);
  endtask

  initial begin
    logic acc;
    logic done;
    logic v, rdy, fl;
    logic [W-1:0] d;

    // 1: reset held two cycles
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk_empty("reset");
    chk("reset_data", {16'd0, out_data}, {16'd0, RV});
    mq.delete();

    // 2: back-to-back stream, downstream always ready
    got.delete();
    for (int i = 1; i <= 8; i++) step(1'b1, W'(i), 1'b1, 1'b0, 1'b0, acc);
    repeat (2) step(1'b0, 'x, 1'b1, 1'b0, 1'b0, acc);
    chk("stream_count", got.size(), 32'd8);
    for (int i = 0; i < got.size(); i++) chk("stream_order", {16'd0, got[i]}, i + 1);

    // 3: fill with downstream stalled, then release
    got.delete();
    step(1'b1, 16'hAAAA, 1'b0, 1'b0, 1'b0, acc);
    step(1'b1, 16'hBBBB, 1'b0, 1'b0, 1'b0, acc);
    #1;
    chk("full_head", {16'd0, out_data}, 32'h0000_AAAA);
    chk("full_ready", {31'd0, in_ready}, 32'd0);
    chk("full_occ", {30'd0, occupancy}, 32'd2);
    step(1'b1, 16'hCCCC, 1'b0, 1'b0, 1'b0, acc);
    done = 1'b0;
    for (int k = 0; k < 10 && !done; k++) begin
      step(1'b1, 16'hCCCC, 1'b1, 1'b0, 1'b0, acc);
      done = acc;
    end
    chk("cccc_accepted", {31'd0, done}, 32'd1);
    repeat (4) step(1'b0, 'x, 1'b1, 1'b0, 1'b0, acc);
    chk("order_count", got.size(), 32'd3);
    if (got.size() == 3) begin
      chk("order_0", {16'd0, got[0]}, 32'h0000_AAAA);
      chk("order_1", {16'd0, got[1]}, 32'h0000_BBBB);
      chk("order_2", {16'd0, got[2]}, 32'h0000_CCCC);
    end

    // 4: flush while full with a new beat offered
    step(1'b1, 16'h1111, 1'b0, 1'b0, 1'b0, acc);
    step(1'b1, 16'h2222, 1'b0, 1'b0, 1'b0, acc);
    got.delete();
    step(1'b1, 16'hDEAD, 1'b0, 1'b1, 1'b0, acc);
    #1;
    chk_empty("flush");
    repeat (3) step(1'b0, 'x, 1'b1, 1'b0, 1'b0, acc);
    chk("flush_no_leak", got.size(), 32'd0);

    // 5: reset while busy and stalled, then one clean beat
    step(1'b1, 16'h7777, 1'b0, 1'b0, 1'b0, acc);
    step(1'b0, 'x, 1'b0, 1'b0, 1'b1, acc);
    #1;
    chk_empty("midrst");
    chk("midrst_data", {16'd0, out_data}, {16'd0, RV});
    got.delete();
    step(1'b1, 16'h1234, 1'b1, 1'b0, 1'b0, acc);
    repeat (3) step(1'b0, 'x, 1'b1, 1'b0, 1'b0, acc);
    chk("post_rst_count", got.size(), 32'd1);
    if (got.size() == 1) chk("post_rst_data", {16'd0, got[0]}, 32'h0000_1234);

    // 6: random traffic; payload is X whenever it must be ignored
    for (int n = 0; n < 10000; n++) begin
      v   = ($urandom_range(0, 3) != 0);
      rdy = ($urandom_range(0, 2) != 0);
      fl  = ($urandom_range(0, 199) == 0);
      d   = (v && mq.size() < 2) ? W'($urandom) : 'x;
      step(v, d, rdy, fl, 1'b0, acc);
    end
    repeat (4) step(1'b0, 'x, 1'b1, 1'b0, 1'b0, acc);
    chk_empty("drain");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
